// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcodes, queue entry layout and
// immediate extraction for static branch pre-decode.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // One buffered fetch: where it came from, what it is, and how we predicted it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred;
    logic [XLEN-1:0] target;
  } fetch_entry_t;

  // J-type immediate, sign-extended to XLEN (bit 0 is always zero).
  function automatic logic [XLEN-1:0] j_imm(input logic [XLEN-1:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended to XLEN (bit 0 is always zero).
  function automatic logic [XLEN-1:0] b_imm(input logic [XLEN-1:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Static branch pre-decode: JAL and backward conditional branches are
// predicted taken; everything else (including JALR) falls through.
module fetch_predecode
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  pred_o,
  output logic [DATA_WIDTH-1:0] target_o
);

  // Classify the word by opcode and form the predicted target.
  always_comb begin
    pred_o   = 1'b0;
    target_o = '0;
    case (instr_i[6:0])
      OPC_JAL: begin
        pred_o   = 1'b1;
        target_o = pc_i + j_imm(instr_i);
      end
      OPC_BRANCH: begin
        if (instr_i[31]) begin
          pred_o   = 1'b1;
          target_o = pc_i + b_imm(instr_i);
        end else begin
          pred_o   = 1'b0;
          target_o = '0;
        end
      end
      default: begin
        pred_o   = 1'b0;
        target_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch queue stage: generates in-order I-cache requests, buffers returned
// words in a small queue with pre-decoded predictions, and presents the head
// to decode. Redirects from execute flush the queue and squash in-flight
// responses; predicted-taken words squash younger in-flight responses.
module fetch_queue_stage
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  ic_req_valid,
  output logic [DATA_WIDTH-1:0] ic_req_addr,
  input  logic                  ic_req_ready,
  input  logic                  ic_resp_valid,
  input  logic [DATA_WIDTH-1:0] ic_resp_data,
  output logic                  valid_d,
  output logic [DATA_WIDTH-1:0] PC_d,
  output logic [DATA_WIDTH-1:0] PCPlus4_d,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic                  predict_taken_d,
  output logic [DATA_WIDTH-1:0] branch_target_d
);

  localparam int                    PW      = $clog2(DEPTH);
  localparam int                    CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]           DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
  localparam logic [PW-1:0]         PTR_ONE = PW'(1);

  // Architectural state
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  // PC of the next response that will actually be kept (not squashed)
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         drop_q, drop_d;
  fetch_entry_t          queue_q [DEPTH];

  // Datapath helpers
  logic                  pd_pred_s;
  logic [DATA_WIDTH-1:0] pd_target_s;
  logic                  resp_keep_s;
  logic                  pred_fire_s;
  logic                  credit_ok_s;
  logic                  issue_s;
  logic                  enq_s;
  logic                  deq_s;
  logic                  head_valid_s;
  fetch_entry_t          head_s;

  fetch_predecode #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_predecode (
    .instr_i  (ic_resp_data),
    .pc_i     (resp_pc_q),
    .pred_o   (pd_pred_s),
    .target_o (pd_target_s)
  );

  // Handshake decisions: which response is kept, whether we may issue, and
  // whether decode consumes the head. Queue occupancy plus in-flight requests
  // never exceeds DEPTH, so every kept response has a free slot.
  always_comb begin
    resp_keep_s  = ic_resp_valid && (drop_q == '0);
    pred_fire_s  = resp_keep_s && pd_pred_s && !redirect_valid;
    credit_ok_s  = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C;
    ic_req_valid = rst_n && !redirect_valid && !pred_fire_s && credit_ok_s;
    ic_req_addr  = fetch_pc_q;
    issue_s      = ic_req_valid && ic_req_ready;
    enq_s        = resp_keep_s && !redirect_valid;
    head_valid_s = rst_n && (count_q != '0);
    deq_s        = en && head_valid_s && !redirect_valid;
  end

  // Next-state for PCs, pointers and counters; a redirect overrides
  // response handling, prediction and dequeue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(issue_s) - CW'(ic_resp_valid);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Every request still in flight after this cycle belongs to the old path.
      drop_d     = outst_q - CW'(ic_resp_valid);
    end else begin
      if (issue_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else if (pred_fire_s) begin
        fetch_pc_d = pd_target_s;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end

      if (enq_s) begin
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        resp_pc_d = pred_fire_s ? pd_target_s : (resp_pc_q + PC_STEP);
      end else begin
        wr_ptr_d  = wr_ptr_q;
        resp_pc_d = resp_pc_q;
      end

      if (pred_fire_s) begin
        // All requests younger than the predicted word are on the wrong path.
        drop_d = outst_q - CW'(1'b1);
      end else if (ic_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1'b1);
      end else begin
        drop_d = drop_q;
      end

      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      count_d = count_q + CW'(enq_s) - CW'(deq_s);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage: write the kept, pre-decoded response at the tail.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        queue_q[i] <= '0;
      end
    end else if (enq_s) begin
      queue_q[wr_ptr_q] <= '{pc:     resp_pc_q,
                             instr:  ic_resp_data,
                             pred:   pd_pred_s,
                             target: pd_target_s};
    end else begin
      queue_q[wr_ptr_q] <= queue_q[wr_ptr_q];
    end
  end

  // Decode-facing view of the head; all fields read zero when empty.
  always_comb begin
    head_s = queue_q[rd_ptr_q];
    if (head_valid_s) begin
      valid_d         = 1'b1;
      PC_d            = head_s.pc;
      PCPlus4_d       = head_s.pc + PC_STEP;
      instr_d         = head_s.instr;
      predict_taken_d = head_s.pred;
      branch_target_d = head_s.target;
    end else begin
      valid_d         = 1'b0;
      PC_d            = '0;
      PCPlus4_d       = '0;
      instr_d         = '0;
      predict_taken_d = 1'b0;
      branch_target_d = '0;
    end
  end

endmodule
